// File: rtl/nmr_param_avmm_loader.sv
// Avalon-MM loader: writes a staged table of NMR acquisition parameters into
// a chain of PIO slaves, then reads each one back and verifies it.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   tbl_wr/tbl_idx/tbl_wdata      table staging port (ignored while busy)
//   base_addr, count, start       load request (sampled on accepted start)
//   busy, done, error, err_idx    status (error is sticky until next start)
//   avm_*                         Avalon-MM master port
module nmr_param_avmm_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int STRIDE = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tbl_wr,
  input  logic [$clog2(DEPTH)-1:0] tbl_idx,
  input  logic [31:0]              tbl_wdata,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [ADDR_W-1:0]        avm_address,
  output logic                     avm_write,
  output logic [31:0]              avm_writedata,
  output logic [3:0]               avm_byteenable,
  output logic                     avm_read,
  input  logic                     avm_waitrequest,
  input  logic [31:0]              avm_readdata,
  input  logic                     avm_readdatavalid
);

  localparam int          IW      = $clog2(DEPTH);
  localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);
  localparam bit          STR_P2  = (STRIDE & (STRIDE - 1)) == 0;
  localparam int          SH      = $clog2(STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD, S_RWAIT, S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [IW-1:0]     err_idx_q, err_idx_d;
  logic [31:0]       tbl_q [DEPTH];

  logic [ADDR_W-1:0] off;
  logic [IW:0]       cnt_m1;
  logic              req;
  logic              rd_hit;

  if (STR_P2) begin : g_shift
    assign off = ADDR_W'(idx_q) << SH;
  end else begin : g_mul
    assign off = ADDR_W'(idx_q) * ADDR_W'(STRIDE);
  end

  assign cnt_m1 = count - (IW+1)'(1);

  // Zero-latency read data arrives in the acceptance cycle of the read.
  assign rd_hit = avm_readdatavalid &&
                  (state_q == S_RWAIT ||
                   (state_q == S_RD && !avm_waitrequest));

  assign busy           = state_q inside {S_WR, S_RD, S_RWAIT};
  assign avm_write      = state_q == S_WR;
  assign avm_read       = state_q == S_RD;
  assign req            = avm_write || avm_read;
  assign avm_address    = req ? base_q + off : '0;
  assign avm_writedata  = avm_write ? tbl_q[idx_q] : '0;
  assign avm_byteenable = req ? 4'hF : 4'h0;
  assign done           = done_q;
  assign error          = error_q;
  assign err_idx        = err_idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    base_d    = base_q;
    done_d    = 1'b0;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d   = 1'b0;
          err_idx_d = '0;
          if (count != '0 && count <= DEPTH_C) begin
            state_d = S_WR;
            idx_d   = '0;
            base_d  = base_addr;
            last_d  = cnt_m1[IW-1:0];
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          if (idx_q == last_q) begin
            state_d = S_RD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_RD: begin
        if (!avm_waitrequest) state_d = S_RWAIT;
      end
      S_RWAIT: ;
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = !error_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_hit) begin
      if (avm_readdata != tbl_q[idx_q]) begin
        error_d   = 1'b1;
        err_idx_d = idx_q;
        state_d   = S_FIN;
      end else if (idx_q == last_q) begin
        state_d = S_FIN;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = S_RD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      base_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      base_q    <= base_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Table survives reset so a reload after an aborted run reuses it.
  always_ff @(posedge clk) begin
    if (tbl_wr && !busy) tbl_q[tbl_idx] <= tbl_wdata;
  end

endmodule

// File: tb/tb_nmr_param_avmm_loader.sv
// Bench for nmr_param_avmm_loader: Avalon slave model with stall/corrupt
// injection and a transaction scoreboard.
module tb_nmr_param_avmm_loader;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tbl_wr = 1'b0;
  logic [2:0]  tbl_idx = '0;
  logic [31:0] tbl_wdata = '0;
  logic [31:0] base_addr = '0;
  logic [3:0]  count = '0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [2:0]  err_idx;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;

  nmr_param_avmm_loader #(.DEPTH(DEPTH), .ADDR_W(32), .STRIDE(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .tbl_wr(tbl_wr), .tbl_idx(tbl_idx), .tbl_wdata(tbl_wdata),
    .base_addr(base_addr), .count(count), .start(start),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx),
    .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] tbl_m [DEPTH];
  logic [64:0] exp_q [$];
  logic [64:0] act_q [$];
  logic [31:0] mem [logic [31:0]];

  // slave configuration (written by tests only)
  logic [31:0] stall_addr = '0;
  int          stall_n = 0;
  int          arm_tag = 0;
  int          clr_tag = 0;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;

  // slave state (written by slave only)
  int          armed_tag = 0;
  int          clred_tag = 0;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  int          req_cycles = 0;
  int          be_bad = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_d = '0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_data = '0;

  // Slave decides waitrequest for the current cycle on the falling edge;
  // read data comes back one cycle after acceptance.
  always @(negedge clk) begin
    if (clr_tag != clred_tag) begin
      clred_tag = clr_tag;
      stall_left = 0;
      pend = 1'b0;
    end
    if (pend) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = pend_d;
      pend = 1'b0;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
    end
    avm_waitrequest = 1'b0;
    if ((avm_write || avm_read) ? avm_byteenable !== 4'hF
                                : avm_byteenable !== 4'h0)
      be_bad++;
    if (avm_write || avm_read) begin
      req_cycles++;
      if (arm_tag != armed_tag && avm_address == stall_addr) begin
        armed_tag = arm_tag;
        stall_left = stall_n;
        s_addr = avm_address;
        s_data = avm_writedata;
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
        stall_seen++;
        if (avm_address !== s_addr || avm_writedata !== s_data)
          stall_bad++;
      end else if (avm_write) begin
        mem[avm_address] = avm_writedata;
        act_q.push_back({1'b1, avm_address, avm_writedata});
      end else begin
        pend = 1'b1;
        if (corrupt_en && avm_address == corrupt_addr)
          pend_d = 32'h0;
        else
          pend_d = mem.exists(avm_address) ? mem[avm_address] : 32'h0;
        act_q.push_back({1'b0, avm_address, 32'h0});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tload(input int idx, input logic [31:0] d);
    @(negedge clk);
    tbl_wr = 1'b1;
    tbl_idx = idx[2:0];
    tbl_wdata = d;
    @(posedge clk);
    #1;
    tbl_wr = 1'b0;
    tbl_m[idx] = d;
  endtask

  task automatic go(input logic [31:0] b, input logic [3:0] c);
    @(negedge clk);
    base_addr = b;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(output int k);
    k = 0;
    while (!(done || error) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic push_exp(input logic [31:0] b, input int c, input int nrd);
    for (int i = 0; i < c; i++)
      exp_q.push_back({1'b1, b + 32'(i * 16), tbl_m[i]});
    for (int i = 0; i < nrd; i++)
      exp_q.push_back({1'b0, b + 32'(i * 16), 32'h0});
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, error, err_idx} !== 6'b0) begin
      fails++;
      $display("FAIL reset_status got=%b exp=0",
               {busy, done, error, err_idx});
    end
    tests++;
    if ({avm_write, avm_read, avm_byteenable} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctl got=%b exp=0",
               {avm_write, avm_read, avm_byteenable});
    end
    tests++;
    if ({avm_address, avm_writedata} !== 64'b0) begin
      fails++;
      $display("FAIL reset_bus got=%h/%h exp=0", avm_address, avm_writedata);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int k, rc0;
    logic [64:0] a, e;
    tload(0, 32'd255);
    tload(1, 32'd1000);
    tload(2, 32'hDEADBEEF);
    tload(3, 32'd7);
    act_q.delete();
    push_exp(32'h100, 4, 4);
    rc0 = req_cycles;
    go(32'h100, 4'd4);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy got=%b exp=1", busy);
    end
    wait_end(k);
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL basic_done got=%b/%b exp=1/0", done, error);
    end
    tests++;
    if (k + 1 !== 3 * 4 + 2) begin
      fails++;
      $display("FAIL basic_latency got=%0d exp=%0d", k + 1, 3 * 4 + 2);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_pulse got=%b exp=0", done);
    end
    tests++;
    if (req_cycles - rc0 !== 8) begin
      fails++;
      $display("FAIL basic_reqcyc got=%0d exp=8", req_cycles - rc0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL basic_txn got=%h exp=%h", a, e);
      end
    end
    tests++;
    if (act_q.size() != 0) begin
      fails++;
      $display("FAIL basic_extra got=%0d exp=0", act_q.size());
    end
  endtask

  task automatic test_stall;
    int k, ss0, sb0;
    logic [64:0] a, e;
    act_q.delete();
    push_exp(32'h100, 4, 4);
    stall_addr = 32'h110;
    stall_n = 3;
    arm_tag++;
    ss0 = stall_seen;
    sb0 = stall_bad;
    go(32'h100, 4'd4);
    wait_end(k);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL stall_done got=%b exp=1", done);
    end
    tests++;
    if (k + 1 !== 3 * 4 + 2 + 3) begin
      fails++;
      $display("FAIL stall_latency got=%0d exp=%0d", k + 1, 17);
    end
    tests++;
    if (stall_seen - ss0 !== 3) begin
      fails++;
      $display("FAIL stall_cycles got=%0d exp=3", stall_seen - ss0);
    end
    tests++;
    if (stall_bad - sb0 !== 0 || s_addr !== 32'h110 || s_data !== 32'd1000) begin
      fails++;
      $display("FAIL stall_stable got=%0d %h %0d exp=0 110 1000",
               stall_bad - sb0, s_addr, s_data);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL stall_txn got=%h exp=%h", a, e);
      end
    end
    tests++;
    if (act_q.size() != 0) begin
      fails++;
      $display("FAIL stall_dup got=%0d exp=0", act_q.size());
    end
  endtask

  task automatic test_mismatch;
    int k;
    logic [64:0] a, e;
    act_q.delete();
    push_exp(32'h100, 4, 3);
    corrupt_addr = 32'h120;
    corrupt_en = 1'b1;
    go(32'h100, 4'd4);
    wait_end(k);
    tests++;
    if (error !== 1'b1 || err_idx !== 3'd2) begin
      fails++;
      $display("FAIL mm_error got=%b/%0d exp=1/2", error, err_idx);
    end
    repeat (2) begin
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL mm_nodone got=%b exp=0", done);
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mm_sticky got=%b/%b exp=1/0", error, busy);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL mm_txn got=%h exp=%h", a, e);
      end
    end
    tests++;
    if (act_q.size() != 0) begin
      fails++;
      $display("FAIL mm_extra got=%0d exp=0", act_q.size());
    end
    corrupt_en = 1'b0;
    go(32'h100, 4'd4);
    tests++;
    if (error !== 1'b0 || err_idx !== 3'd0) begin
      fails++;
      $display("FAIL mm_clear got=%b/%0d exp=0/0", error, err_idx);
    end
    wait_end(k);
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL mm_rerun got=%b/%b exp=1/0", done, error);
    end
    @(posedge clk);
    act_q.delete();
  endtask

  task automatic test_bad_count;
    int rc0;
    logic [3:0] cv [2];
    cv[0] = 4'd0;
    cv[1] = 4'(DEPTH + 1);
    foreach (cv[j]) begin
      rc0 = req_cycles;
      go(32'h100, cv[j]);
      tests++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
        fails++;
        $display("FAIL badcnt_done cnt=%0d got=%b%b%b exp=100",
                 cv[j], done, busy, error);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b0 || req_cycles - rc0 !== 0) begin
        fails++;
        $display("FAIL badcnt_quiet cnt=%0d got=%b/%0d exp=0/0",
                 cv[j], done, req_cycles - rc0);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int k;
    logic [64:0] a, e;
    act_q.delete();
    push_exp(32'h100, 4, 4);
    go(32'h100, 4'd4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    base_addr = 32'h9000;
    count = 4'd1;
    tbl_wr = 1'b1;
    tbl_idx = 3'd0;
    tbl_wdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    start = 1'b0;
    tbl_wr = 1'b0;
    wait_end(k);
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL busy_done got=%b/%b exp=1/0", done, error);
    end
    push_exp(32'h100, 1, 1);
    @(posedge clk);
    go(32'h100, 4'd1);
    wait_end(k);
    tests++;
    if (done !== 1'b1 || k !== 4) begin
      fails++;
      $display("FAIL busy_rerun got=%b/%0d exp=1/4", done, k);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL busy_txn got=%h exp=%h", a, e);
      end
    end
    tests++;
    if (act_q.size() != 0) begin
      fails++;
      $display("FAIL busy_extra got=%0d exp=0", act_q.size());
    end
  endtask

  task automatic test_async_reset;
    int k, n;
    logic [64:0] a, e;
    act_q.delete();
    stall_addr = 32'h120;
    stall_n = 20;
    arm_tag++;
    go(32'h100, 4'd4);
    n = 0;
    while (!(avm_write && avm_address == 32'h120 && avm_waitrequest)
           && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL arst_reach got=timeout exp=stalled third write");
    end
    #1;
    reset_n = 1'b0;
    #1;
    tests++;
    if (avm_write !== 1'b0 || busy !== 1'b0 || avm_address !== 32'h0) begin
      fails++;
      $display("FAIL arst_async got=%b/%b/%h exp=0/0/0",
               avm_write, busy, avm_address);
    end
    clr_tag++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    act_q.delete();
    push_exp(32'h100, 4, 4);
    go(32'h100, 4'd4);
    wait_end(k);
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL arst_reload got=%b/%b exp=1/0", done, error);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL arst_txn got=%h exp=%h", a, e);
      end
    end
    tests++;
    if (act_q.size() != 0) begin
      fails++;
      $display("FAIL arst_extra got=%0d exp=0", act_q.size());
    end
  endtask

  task automatic test_wrap;
    int k;
    logic [64:0] a, e;
    act_q.delete();
    push_exp(32'hFFFF_FFF0, 2, 2);
    go(32'hFFFF_FFF0, 4'd2);
    wait_end(k);
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL wrap_done got=%b/%b exp=1/0", done, error);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL wrap_txn got=%h exp=%h", a, e);
      end
    end
    tests++;
    if (act_q.size() != 0 || be_bad != 0) begin
      fails++;
      $display("FAIL wrap_extra got=%0d/%0d exp=0/0", act_q.size(), be_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mismatch();
    test_bad_count();
    test_busy_ignore();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
